// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module   : multicycle_controller_if
// Purpose  : Controller <-> datapath signal bundle for the multicycle RV32I core
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       Zero;
   logic       ALUR31;
   logic       MemReady;
   logic       PCWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic       ALUUnsigned;
   logic [2:0] ImmSrc;
   logic       Illegal;
   logic [3:0] state;

   modport master (
      input  op, funct3, Zero, ALUR31, MemReady,
      output PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ALUUnsigned, ImmSrc, Illegal, state
   );

   modport slave (
      output op, funct3, Zero, ALUR31, MemReady,
      input  PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUOp, ALUUnsigned, ImmSrc, Illegal, state
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Control FSM sequencing the shared multicycle RV32I datapath
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_controller (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_JALR1    = 4'd10,
      S_JALR2    = 4'd11,
      S_BRANCH   = 4'd12,
      S_UIMM     = 4'd13,
      S_ILLEGAL  = 4'd14
   } state_t;

   localparam logic [6:0] c_OP_LW     = 7'b0000011;
   localparam logic [6:0] c_OP_SW     = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;

   always_comb begin
      state_d         = state_q;
      bus.PCWrite     = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.AdrSrc      = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ResultSrc   = 2'b00;
      bus.ALUSrcA     = 2'b00;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 2'b00;
      bus.ALUUnsigned = 1'b0;
      bus.ImmSrc      = 3'b000;
      bus.Illegal     = 1'b0;

      case (bus.op)
         c_OP_SW:              bus.ImmSrc = 3'b001;
         c_OP_BRANCH:          bus.ImmSrc = 3'b010;
         c_OP_JAL:             bus.ImmSrc = 3'b011;
         c_OP_LUI, c_OP_AUIPC: bus.ImmSrc = 3'b100;
         default:              bus.ImmSrc = 3'b000;
      endcase

      case (state_q)
         S_FETCH: begin
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            bus.IRWrite   = bus.MemReady;
            bus.PCWrite   = bus.MemReady;
            if (bus.MemReady) state_d = S_DECODE;
         end
         S_DECODE: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            case (bus.op)
               c_OP_LW, c_OP_SW:     state_d = S_MEMADR;
               c_OP_RTYPE:           state_d = S_EXECUTER;
               c_OP_ITYPE:           state_d = S_EXECUTEI;
               c_OP_JAL:             state_d = S_JAL;
               c_OP_JALR:            state_d = S_JALR1;
               c_OP_BRANCH:          state_d = S_BRANCH;
               c_OP_LUI, c_OP_AUIPC: state_d = S_UIMM;
               default:              state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            state_d     = (bus.op == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            bus.AdrSrc = 1'b1;
            if (bus.MemReady) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            bus.ResultSrc = 2'b01;
            bus.RegWrite  = 1'b1;
            state_d       = S_FETCH;
         end
         S_MEMWRITE: begin
            bus.AdrSrc   = 1'b1;
            bus.MemWrite = 1'b1;
            if (bus.MemReady) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b10;
            state_d     = S_ALUWB;
         end
         S_EXECUTEI: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            bus.ALUOp   = 2'b10;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            bus.RegWrite = 1'b1;
            state_d      = S_FETCH;
         end
         // JALR2 reuses the JAL datapath: PC <- ALUOut, ALUOut <- OldPC + 4
         S_JAL, S_JALR2: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b10;
            bus.PCWrite = 1'b1;
            state_d     = S_ALUWB;
         end
         S_JALR1: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUSrcB = 2'b01;
            state_d     = S_JALR2;
         end
         S_BRANCH: begin
            bus.ALUSrcA = 2'b10;
            bus.ALUOp   = 2'b01;
            case (bus.funct3)
               3'b000: bus.PCWrite = bus.Zero;
               3'b001: bus.PCWrite = ~bus.Zero;
               3'b100: bus.PCWrite = bus.ALUR31;
               3'b101: bus.PCWrite = ~bus.ALUR31;
               3'b110: begin
                  bus.PCWrite     = bus.ALUR31;
                  bus.ALUUnsigned = 1'b1;
               end
               3'b111: begin
                  bus.PCWrite     = ~bus.ALUR31;
                  bus.ALUUnsigned = 1'b1;
               end
               default: bus.PCWrite = 1'b0;
            endcase
            state_d = S_FETCH;
         end
         S_UIMM: begin
            bus.ALUSrcA = (bus.op == c_OP_LUI) ? 2'b11 : 2'b01;
            bus.ALUSrcB = 2'b01;
            state_d     = S_ALUWB;
         end
         S_ILLEGAL: begin
            bus.Illegal = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // The FSM is already back in FETCH while reset is held; keep it inert.
      if (reset) begin
         bus.PCWrite  = 1'b0;
         bus.IRWrite  = 1'b0;
         bus.MemWrite = 1'b0;
         bus.RegWrite = 1'b0;
         bus.Illegal  = 1'b0;
      end
   end

endmodule

`default_nettype wire
